// File: rtl/loop_control_pkg.sv
// Shared types and defaults for the LOOP/CONTROL gate sequencing blocks.
package loop_control_pkg;

    // Default width of the sequencer cycle counters and on-time report.
    localparam int CNT_W_DEFAULT = 8;

    // Sequencer phases: dead-time wait, high-side on, low-side off, delay fault.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DEAD  = 3'd1,
        ON    = 3'd2,
        OFF   = 3'd3,
        FAULT = 3'd4
    } state_t;

endpackage

// File: rtl/loop_control_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the CELCLK domain.
module loop_control_sync2 (
    input  logic CELCLK,
    input  logic CELRST,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops; both clear on reset.
    always_ff @(posedge CELCLK) begin
        // NOTE: non-blocking assignments let both flops sample the old values, so this stays a true two-stage shift.
        if (CELRST) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/loop_control_pwm_sequencer.sv
// Per-period gate sequencer: launches an edge into the fixed delay cell, uses
// the returned edge as the dead-time reference, then runs high-side on-time
// (blanked, min/max limited) followed by a fixed low-side off-time.
module loop_control_pwm_sequencer
    import loop_control_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int MIN_ON      = 4,
    parameter int MAX_ON      = 200,
    parameter int MIN_OFF     = 4,
    parameter int DLY_TIMEOUT = 16
) (
    input  logic             CELCLK,
    input  logic             CELRST,
    input  logic             en,
    input  logic             start,
    input  logic             comp_trip,
    input  logic             dly_o,
    output logic             dly_i,
    output logic             hs_on,
    output logic             ls_on,
    output logic             busy,
    output logic             fault_dly,
    output logic [CNT_W-1:0] on_cycles
);

    // Terminal counts, pre-sized to the counter width.
    localparam logic [CNT_W-1:0] MIN_ON_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] MAX_ON_LAST  = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] MIN_OFF_LAST = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] DLY_LAST     = CNT_W'(DLY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dly_s;

    loop_control_sync2 u_dly_sync (
        .CELCLK (CELCLK),
        .CELRST (CELRST),
        .d      (dly_o),
        .q      (dly_s)
    );

    // Single-process FSM: every output is registered from the state being entered.
    always_ff @(posedge CELCLK) begin
        if (CELRST) begin
            state     <= IDLE;
            cnt       <= '0;
            dly_i     <= 1'b0;
            hs_on     <= 1'b0;
            ls_on     <= 1'b0;
            busy      <= 1'b0;
            fault_dly <= 1'b0;
            on_cycles <= '0;
        end else if (!en) begin
            // Abort: drop gates and fault, keep the last reported on-time.
            state     <= IDLE;
            cnt       <= '0;
            dly_i     <= 1'b0;
            hs_on     <= 1'b0;
            ls_on     <= 1'b0;
            busy      <= 1'b0;
            fault_dly <= 1'b0;
        end else begin
            // Outputs default to the IDLE decode; each transition raises what its target needs.
            dly_i     <= 1'b0;
            hs_on     <= 1'b0;
            ls_on     <= 1'b0;
            busy      <= 1'b0;
            fault_dly <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        state <= DEAD;
                        dly_i <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                DEAD: begin
                    // The returned edge wins over a coincident timeout.
                    if (dly_s) begin
                        state <= ON;
                        cnt   <= '0;
                        dly_i <= 1'b1;
                        hs_on <= 1'b1;
                        busy  <= 1'b1;
                    end else if (cnt == DLY_LAST) begin
                        state     <= FAULT;
                        cnt       <= '0;
                        fault_dly <= 1'b1;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                        dly_i <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                ON: begin
                    // Trip is only honoured once the blanking window has elapsed.
                    if ((comp_trip && (cnt >= MIN_ON_LAST)) || (cnt == MAX_ON_LAST)) begin
                        state     <= OFF;
                        on_cycles <= cnt + CNT_ONE;
                        cnt       <= '0;
                        ls_on     <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                        dly_i <= 1'b1;
                        hs_on <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                OFF: begin
                    // A start tick arriving here is simply not looked at.
                    if (cnt == MIN_OFF_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                        ls_on <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                FAULT: begin
                    // Sticky until en drops.
                    cnt       <= '0;
                    fault_dly <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loop_control_pwm_sequencer.sv
// Directed bench for loop_control_pwm_sequencer with a 2-cycle delay-cell model.
module tb_loop_control_pwm_sequencer;

    localparam int CNT_W = 8;

    logic             CELCLK = 1'b0;
    logic             CELRST = 1'b1;
    logic             en = 1'b0;
    logic             start = 1'b0;
    logic             comp_trip = 1'b0;
    logic             dly_o;
    logic             dly_i;
    logic             hs_on;
    logic             ls_on;
    logic             busy;
    logic             fault_dly;
    logic [CNT_W-1:0] on_cycles;

    int total = 0;
    int bad = 0;
    int overlap_cnt = 0;

    // Delay-cell model: dly_o follows dly_i two clocks later when the cell works.
    logic       cell_ok = 1'b1;
    logic [1:0] dly_pipe = 2'b00;

    always #5 CELCLK = ~CELCLK;

    always @(posedge CELCLK) dly_pipe <= {dly_pipe[0], dly_i & cell_ok};
    assign dly_o = dly_pipe[1];

    // Gate commands must never overlap.
    always @(negedge CELCLK) if (hs_on && ls_on) overlap_cnt++;

    loop_control_pwm_sequencer #(
        .CNT_W       (CNT_W),
        .MIN_ON      (4),
        .MAX_ON      (200),
        .MIN_OFF     (4),
        .DLY_TIMEOUT (16)
    ) dut (
        .CELCLK    (CELCLK),
        .CELRST    (CELRST),
        .en        (en),
        .start     (start),
        .comp_trip (comp_trip),
        .dly_o     (dly_o),
        .dly_i     (dly_i),
        .hs_on     (hs_on),
        .ls_on     (ls_on),
        .busy      (busy),
        .fault_dly (fault_dly),
        .on_cycles (on_cycles)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock edge, then settle on the falling edge for sampling and driving.
    task automatic tick();
        @(posedge CELCLK);
        @(negedge CELCLK);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Run one full period; comp_trip rises once the ON counter reaches trip_at.
    task automatic run_cycle(input int trip_at, input bit start_in_off,
                             output int hs_cnt, output int ls_cnt, output bit timed_out);
        int cyc;
        hs_cnt = 0;
        ls_cnt = 0;
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (busy && cyc < 400) begin
            if (hs_on) hs_cnt++;
            if (ls_on) ls_cnt++;
            comp_trip = (hs_cnt > trip_at);
            start = start_in_off && ls_on && (ls_cnt == 1);
            tick();
            cyc++;
        end
        start = 1'b0;
        comp_trip = 1'b0;
        timed_out = (cyc >= 400);
    endtask

    task automatic wait_hs(input string tag);
        int n;
        n = 0;
        while (!hs_on && n < 20) begin
            tick();
            n++;
        end
        check(tag, hs_on, 1'b1);
    endtask

    initial begin
        int  hs_cnt;
        int  ls_cnt;
        bit  tmo;

        // Reset state.
        @(negedge CELCLK);
        idle_ticks(2);
        check("rst_dly_i", dly_i, 0);
        check("rst_hs_on", hs_on, 0);
        check("rst_ls_on", ls_on, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault_dly, 0);
        check("rst_on_cycles", on_cycles, 0);
        CELRST = 1'b0;
        en = 1'b1;
        tick();

        // Start latency: dly_i rises on the edge that samples start.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lat_dly_i", dly_i, 1);
        check("lat_busy", busy, 1);
        check("lat_hs_off", hs_on, 0);
        en = 1'b0;
        tick();
        en = 1'b1;
        idle_ticks(5);

        // Nominal: trip at ON count 10 -> 11 cycles on, 4 off.
        run_cycle(10, 1'b0, hs_cnt, ls_cnt, tmo);
        check("nom_timeout", tmo, 0);
        check("nom_hs_cycles", hs_cnt, 11);
        check("nom_ls_cycles", ls_cnt, 4);
        check("nom_on_cycles", on_cycles, 11);
        check("nom_busy_end", busy, 0);
        idle_ticks(2);

        // Blanking: trip held from ON entry -> minimum on-time.
        run_cycle(0, 1'b0, hs_cnt, ls_cnt, tmo);
        check("blank_timeout", tmo, 0);
        check("blank_hs_cycles", hs_cnt, 4);
        check("blank_on_cycles", on_cycles, 4);
        idle_ticks(2);

        // Max on-time: no trip at all.
        run_cycle(1000, 1'b0, hs_cnt, ls_cnt, tmo);
        check("max_timeout", tmo, 0);
        check("max_hs_cycles", hs_cnt, 200);
        check("max_ls_cycles", ls_cnt, 4);
        check("max_on_cycles", on_cycles, 200);
        idle_ticks(2);

        // start during OFF is dropped.
        run_cycle(5, 1'b1, hs_cnt, ls_cnt, tmo);
        check("drop_hs_cycles", hs_cnt, 6);
        check("drop_on_cycles", on_cycles, 6);
        idle_ticks(3);
        check("drop_busy", busy, 0);
        check("drop_dly_i", dly_i, 0);

        // Abort mid-ON: gates drop next edge, on_cycles untouched.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_hs("abort_reach_on");
        idle_ticks(3);
        en = 1'b0;
        tick();
        check("abort_hs_on", hs_on, 0);
        check("abort_ls_on", ls_on, 0);
        check("abort_dly_i", dly_i, 0);
        check("abort_busy", busy, 0);
        check("abort_on_cycles", on_cycles, 6);
        en = 1'b1;
        idle_ticks(5);

        // Delay timeout: fault exactly 16 cycles after dly_i rises.
        cell_ok = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("flt_dly_i_rise", dly_i, 1);
        idle_ticks(15);
        check("flt_not_yet", fault_dly, 0);
        check("flt_busy_wait", busy, 1);
        tick();
        check("flt_set", fault_dly, 1);
        check("flt_dly_i", dly_i, 0);
        check("flt_hs_on", hs_on, 0);
        check("flt_ls_on", ls_on, 0);
        check("flt_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("flt_start_ign_busy", busy, 0);
        check("flt_start_ign_dly", dly_i, 0);
        check("flt_sticky", fault_dly, 1);
        en = 1'b0;
        tick();
        check("flt_clear", fault_dly, 0);
        en = 1'b1;
        cell_ok = 1'b1;
        idle_ticks(3);
        run_cycle(10, 1'b0, hs_cnt, ls_cnt, tmo);
        check("rec_hs_cycles", hs_cnt, 11);
        check("rec_on_cycles", on_cycles, 11);
        check("rec_fault", fault_dly, 0);
        idle_ticks(2);

        // Reset mid-ON behaves like power-on reset.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_hs("mrst_reach_on");
        idle_ticks(2);
        CELRST = 1'b1;
        tick();
        CELRST = 1'b0;
        check("mrst_hs_on", hs_on, 0);
        check("mrst_dly_i", dly_i, 0);
        check("mrst_busy", busy, 0);
        check("mrst_fault", fault_dly, 0);
        check("mrst_on_cycles", on_cycles, 0);
        idle_ticks(6);
        check("mrst_stays_idle", busy, 0);

        check("gate_overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
